// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared types and helpers for the FIFO-draining UART transmitter.
//   state_e        : transmitter FSM states (PARITY only used when the
//                    UART_TX_PARITY_EN macro is defined)
//   IDLE_LEVEL     : serial line level while no frame is on the wire
//   calc_baud_div  : clocks per bit, integer-truncated
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic IDLE_LEVEL = 1'b1;

    function automatic int calc_baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx_if
// Bundles the FIFO pop-side handshake and the serial line outputs.
//   i_fifo_empty : FIFO empty flag
//   i_fifo_data  : FIFO registered read data (valid the cycle after a pop)
//   o_fifo_pop   : one-cycle pop request per frame
//   o_tx         : serial line, idle high
//   o_tx_busy    : frame in progress (POP through STOP)
//   o_tx_done    : one-cycle pulse on the last clock of the stop bit
// Modports: master = transmitter side, slave = FIFO / line side.
// -----------------------------------------------------------------------------
interface fifo_uart_tx_if #(
    parameter int BIT_WIDTH = 8
);

    logic                 i_fifo_empty;
    logic [BIT_WIDTH-1:0] i_fifo_data;
    logic                 o_fifo_pop;
    logic                 o_tx;
    logic                 o_tx_busy;
    logic                 o_tx_done;

    modport master (
        input  i_fifo_empty,
        input  i_fifo_data,
        output o_fifo_pop,
        output o_tx,
        output o_tx_busy,
        output o_tx_done
    );

    modport slave (
        output i_fifo_empty,
        output i_fifo_data,
        input  o_fifo_pop,
        input  o_tx,
        input  o_tx_busy,
        input  o_tx_done
    );

endinterface

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Bit-period counter. Counts 0..BAUD_DIV-1 while enabled and wraps; the tick
// is high on the last count of each bit period.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   en    : count enable (a frame bit is on the wire)
//   clr   : synchronous clear, dominates en
//   tick  : last clock of the current bit period
// -----------------------------------------------------------------------------
module baud_tick_gen #(
    parameter int BAUD_DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: every variable driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: flops use non-blocking assignments so all registers update from
    // the same pre-edge values, matching hardware regardless of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // en comes from the FSM state register, so tick has no input-to-output path.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// fifo_uart_tx
// Drains a byte FIFO from its pop side and sends each word as a UART frame:
// start bit, BIT_WIDTH data bits LSB first, optional even parity, stop bit.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fifo_uart_tx_if.master (FIFO handshake + serial line outputs)
// Parameters: CLK_FREQ (Hz), BAUD (bit/s), BIT_WIDTH (data bits per frame).
// -----------------------------------------------------------------------------
module fifo_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int BIT_WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    fifo_uart_tx_if.master bus
);

    localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
    localparam int IDX_W    = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(BIT_WIDTH - 1);

    state_e               state_q;
    state_e               state_d;
    logic [BIT_WIDTH-1:0] shift_q;
    logic [BIT_WIDTH-1:0] shift_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
    logic                 parity_d;
`endif

    logic baud_en;
    logic baud_clr;
    logic bit_tick;

    // The counter runs only while a frame bit is on the wire and is cleared
    // in LOAD so the start bit always gets a full period.
    assign baud_en  = state_q inside {START, DATA, PARITY, STOP};
    assign baud_clr = (state_q == LOAD);

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (baud_en),
        .clr   (baud_clr),
        .tick  (bit_tick)
    );

    // Next-state and datapath updates.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                // empty is only looked at here; mid-frame changes are ignored.
                if (!bus.i_fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                // Read data is registered in the FIFO: valid one cycle after pop.
                shift_d   = bus.i_fifo_data;
                bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                parity_d  = ^bus.i_fifo_data;
`endif
                state_d   = START;
            end
            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode the state register and datapath flops only.
    always_comb begin
        bus.o_tx       = IDLE_LEVEL;
        bus.o_fifo_pop = 1'b0;
        bus.o_tx_busy  = (state_q != IDLE);
        bus.o_tx_done  = 1'b0;
        unique case (state_q)
            POP:    bus.o_fifo_pop = 1'b1;
            START:  bus.o_tx       = 1'b0;
            DATA:   bus.o_tx       = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: bus.o_tx       = parity_q;
`endif
            STOP: begin
                bus.o_tx      = IDLE_LEVEL;
                bus.o_tx_done = bit_tick;
            end
            default: ;
        endcase
    end

    // NOTE: the shift register is datapath, but it is reset along with the
    // control state so a frame aborted by reset leaves nothing stale behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_fifo_uart_tx
// Self-checking bench for fifo_uart_tx with CLK_FREQ=100, BAUD=10 (10 clocks
// per bit). A queue stands in for the FIFO; expected line levels are built
// per byte from the frame format (start, data LSB first, parity, stop).
// Build with +define+UART_TX_PARITY_EN to exercise the parity variant.
// -----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CLK_FREQ  = 100;
    localparam int BAUD      = 10;
    localparam int BIT_WIDTH = 8;
    localparam int DIV       = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = BIT_WIDTH + 3;
`else
    localparam int NBITS = BIT_WIDTH + 2;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    fifo_uart_tx_if #(.BIT_WIDTH(BIT_WIDTH)) bus ();

    fifo_uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .BIT_WIDTH (BIT_WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total        = 0;
    int bad          = 0;
    int pop_on_empty = 0;

    logic [BIT_WIDTH-1:0] fifo_q[$];

    // FIFO model: registered read data, one word per pop.
    always @(posedge clk) begin
        if (bus.o_fifo_pop) begin
            if (fifo_q.size() > 0) begin
                bus.i_fifo_data <= fifo_q.pop_front();
            end else begin
                pop_on_empty <= pop_on_empty + 1;
            end
        end
    end

    always @(negedge clk) begin
        bus.i_fifo_empty = (fifo_q.size() == 0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Waits (bounded) for the pop of the next frame, then checks every clock
    // of the frame against levels derived from the byte. waited = negedges
    // from entry up to and including the pop cycle.
    task automatic check_frame(input logic [BIT_WIDTH-1:0] b, output int waited);
        logic lv[NBITS];
        lv[0] = 1'b0;
        for (int i = 0; i < BIT_WIDTH; i++) lv[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
        lv[BIT_WIDTH+1] = ^b;
`endif
        lv[NBITS-1] = 1'b1;

        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.o_fifo_pop && waited < 200);
        check("pop_seen", bus.o_fifo_pop, 1);
        if (!bus.o_fifo_pop) return;
        check("pop_busy", bus.o_tx_busy, 1);
        check("pop_tx", bus.o_tx, 1);

        @(negedge clk);
        check("pop_width", bus.o_fifo_pop, 0);
        check("load_tx", bus.o_tx, 1);
        check("load_busy", bus.o_tx_busy, 1);

        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                check($sformatf("tx_b%0d_c%0d", i, c), bus.o_tx, lv[i]);
                check($sformatf("done_b%0d_c%0d", i, c), bus.o_tx_done,
                      (i == NBITS - 1 && c == DIV - 1));
                check("frame_busy", bus.o_tx_busy, 1);
                check("frame_pop", bus.o_fifo_pop, 0);
            end
        end

        @(negedge clk);
        check("end_busy", bus.o_tx_busy, 0);
        check("end_tx", bus.o_tx, 1);
        check("end_done", bus.o_tx_done, 0);
    endtask

    task automatic wait_pop(output bit seen);
        int n = 0;
        seen = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (bus.o_fifo_pop) begin
                seen = 1'b1;
                break;
            end
        end
        check("wait_pop", seen, 1);
    endtask

    initial begin
        int w;
        bit seen;
        logic [BIT_WIDTH-1:0] rb;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_tx", bus.o_tx, 1);
        check("rst_pop", bus.o_fifo_pop, 0);
        check("rst_busy", bus.o_tx_busy, 0);
        check("rst_done", bus.o_tx_done, 0);
        reset = 1'b1;

        // Empty FIFO for 500 cycles: nothing happens.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            check("idle_pop", bus.o_fifo_pop, 0);
            check("idle_tx", bus.o_tx, 1);
            check("idle_busy", bus.o_tx_busy, 0);
        end

        // Single frame.
        fifo_q.push_back(8'hA5);
        check_frame(8'hA5, w);

        // Back-to-back frames: 3 idle-high cycles between them.
        fifo_q.push_back(8'h00);
        fifo_q.push_back(8'hFF);
        check_frame(8'h00, w);
        check_frame(8'hFF, w);
        check("b2b_gap", w, 1);

        // Reset during the start bit: line must rise before the next edge.
        rb = BIT_WIDTH'($urandom);
        fifo_q.push_back(rb);
        wait_pop(seen);
        repeat (3) @(negedge clk);
        check("start_low", bus.o_tx, 0);
        #1 reset = 1'b0;
        #1;
        check("async_tx", bus.o_tx, 1);
        check("async_busy", bus.o_tx_busy, 0);
        check("async_pop", bus.o_fifo_pop, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset during the third data bit of 0x3C, then a clean 0x81.
        fifo_q.push_back(8'h3C);
        wait_pop(seen);
        repeat (2 + 3 * DIV + 4) @(negedge clk);
        check("bit2_tx", bus.o_tx, 1);
        check("bit2_busy", bus.o_tx_busy, 1);
        #1 reset = 1'b0;
        #1;
        check("mid_rst_tx", bus.o_tx, 1);
        check("mid_rst_busy", bus.o_tx_busy, 0);
        fifo_q.push_back(8'h81);
        repeat (4) @(negedge clk);
        check("held_pop", bus.o_fifo_pop, 0);
        check("held_tx", bus.o_tx, 1);
        reset = 1'b1;
        check_frame(8'h81, w);

        // Parity-relevant bytes (odd and even popcount).
        fifo_q.push_back(8'h07);
        check_frame(8'h07, w);
        fifo_q.push_back(8'h03);
        check_frame(8'h03, w);

        // Random bytes with random idle gaps.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(0, 20)) @(negedge clk);
            rb = BIT_WIDTH'($urandom);
            fifo_q.push_back(rb);
            check_frame(rb, w);
        end

        repeat (20) @(negedge clk);
        check("pop_on_empty", pop_on_empty, 0);
        check("fifo_drained", fifo_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
